l1_data_cache: RTL and testbench
================================

# l1_data_cache

Direct-mapped, write-back, write-allocate L1 data cache that sits directly downstream of the core's load/store path. It takes the ALU-computed address, store data, mask and read/write enables, and returns load data. It holds the core with `cpu_stall` while a miss is serviced over a simple request/ready handshake to the next memory level. This is the first per-core cache of the multicore cache-controller design.

## Interface

Parameters:

- `SETS`, 64: number of lines, power of two. Index width `IW = log2(SETS)`.
- Line size is one 32-bit word. Tag width is `TW = 30 - IW`.

Ports:

- `clk`  in  1  clock, rising edge.
- `reset`  in  1  asynchronous, active-low reset.
- `cpu_addr`  in  32  byte address.
- `cpu_wdata`  in  32  store data, LSB-aligned.
- `cpu_mask`  in  3  RISC-V funct3.
  - Loads: 000 LB, 001 LH, 010 LW, 100 LBU, 101 LHU.
  - Stores: 000 SB, 001 SH, 010 SW.
- `cpu_rd_en`  in  1  load request.
- `cpu_wr_en`  in  1  store request.
- `cpu_rdata`  out  32  load data, sign/zero-extended per mask.
- `cpu_stall`  out  1  core must hold PC and all request inputs.
- `mem_req`  out  1  next-level request valid.
- `mem_we`  out  1  1 = write-back, 0 = fill.
- `mem_addr`  out  32  word-aligned address; bits [1:0] = 0.
- `mem_wdata`  out  32  victim line data.
- `mem_rdata`  in  32  fill data, valid when `mem_ready` = 1.
- `mem_ready`  in  1  request completes this cycle.
- `hit_count`  out  32  saturating count of completed hits.
- `miss_count`  out  32  saturating count of misses.

## Operation

Address fields:

- offset = `cpu_addr[1:0]`
- index = `cpu_addr[IW+1:2]`
- tag = `cpu_addr[31:IW+2]`

Per-line storage: valid, dirty, tag, 32-bit data.

The FSM has three states: IDLE, WRITEBACK, ALLOCATE.

**IDLE**
- A request is `cpu_rd_en | cpu_wr_en`. Lookup is combinational.
- If `cpu_wr_en` and `cpu_rd_en` are both high, the access is a store; `cpu_rdata` shows the pre-store word.
- Hit = valid & tag match.
  - Load hit: `cpu_rdata` is valid in the same cycle and `cpu_stall` = 0.
  - Store hit: the line is byte-merged at the clock edge and dirty is set to 1. `cpu_stall` = 0.
  - `hit_count` increments.
- Miss: `cpu_stall` = 1 combinationally in the same cycle, and `miss_count` increments.
  - If the victim is valid & dirty, next state is WRITEBACK.
  - Otherwise, next state is ALLOCATE.
- With no request, `cpu_rdata` = 0.

**WRITEBACK**
- Drives `mem_req` = 1, `mem_we` = 1, `mem_addr` = {victim tag, index, 2'b00}, `mem_wdata` = victim data.
- On `mem_ready`, next state is ALLOCATE.

**ALLOCATE**
- Drives `mem_req` = 1, `mem_we` = 0, `mem_addr` = {tag, index, 2'b00}.
- On `mem_ready`: the line is written with `mem_rdata`, tag is set, valid = 1, dirty = 0. Next state is IDLE.

**Replay**
- Back in IDLE, the held request is looked up again and hits.
- A store completes at that point and sets dirty.
- `cpu_stall` stays 1 in WRITEBACK and ALLOCATE; it drops only at the replay hit.
- The replay counts as a hit; the original access has already counted as a miss.

**Data alignment**
- Byte lane = offset. Halfword lane = `offset[1]`; `offset[0]` is ignored. Word accesses ignore the offset.
- Stores merge only the selected bytes.
- Loads select the lane, then sign-extend (LB, LH) or zero-extend (LBU, LHU).
- Any undefined mask is treated as a word access.

**Counters** saturate at 0xFFFF_FFFF.

## Timing

- Reset (asserted low, asynchronous):
  - All valid and dirty bits clear; state = IDLE.
  - `mem_req`, `mem_we` = 0; `mem_addr`, `mem_wdata` = 0; `cpu_rdata` = 0; `cpu_stall` = 0; both counters = 0.
  - Tag and data arrays need no reset.
- Reset mid-miss: the transaction is abandoned. `mem_req` falls immediately, with no partial line update.
- Hit latency is 0 cycles (combinational read, write at the edge).
- Clean miss costs 1 + Na + 1 cycles: one detect cycle, Na ALLOCATE cycles including the `mem_ready` cycle, and one replay cycle.
- Dirty miss additionally costs Nw WRITEBACK cycles.
- `mem_req`, `mem_we`, `mem_addr` and `mem_wdata` are registered/state-decoded and stable until `mem_ready` is sampled high.
- `mem_ready` is ignored while `mem_req` = 0.
- `mem_ready` held permanently high: a dirty miss takes exactly 1 + 1 + 1 + 1 = 4 cycles of stall-or-replay.
- The request inputs are assumed held while `cpu_stall` = 1. The FSM latches the miss address at detect, so a change in the inputs cannot corrupt the fill.

## Test plan

1. **Cold-load miss.** Reset, then LW 0x0000_0100 with memory returning 0xDEAD_BEEF after 3 cycles.
   - `mem_req`/`mem_we` = 1/0 with `mem_addr` 0x100.
   - Stall lasts 5 cycles, then `cpu_rdata` = 0xDEAD_BEEF.
   - `miss_count` = 1, `hit_count` = 1.
2. **Store hit, then extended loads.** SB 0x80 to 0x101 on the line above, then LB 0x101 and LBU 0x101.
   - No stall on any access.
   - LB returns 0xFFFF_FF80; LBU returns 0x0000_0080.
3. **Dirty eviction.** Access 0x100 + SETS*4 (same index, new tag).
   - WRITEBACK first: `mem_we` = 1, `mem_addr` 0x100, `mem_wdata` 0xDEAD_80EF.
   - Then ALLOCATE at the new address.
4. **Halfword alignment.** SH 0x1234 to 0x102, then LH 0x102 → 0x0000_1234. Then LW 0x100 → upper half 0x1234, lower half unchanged.
5. **Simultaneous enables.** `cpu_rd_en` = `cpu_wr_en` = 1 on a hit.
   - The access is treated as a store.
   - `cpu_rdata` shows the old word and the line becomes dirty.
6. **Reset mid-miss.** Assert reset during ALLOCATE.
   - `mem_req` drops asynchronously and the counters clear.
   - After reset, the same load misses again.

Source files
------------

// File: rtl/l1_data_cache.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | l1_data_cache: direct-mapped, write-back, write-allocate L1 data cache     |
// | with one-word lines. Rev 1.0                                               |
// +----------------------------------------------------------------------------+
module l1_data_cache #(
  parameter int SETS = 64
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] cpu_addr,
  input  logic [31:0] cpu_wdata,
  input  logic [2:0]  cpu_mask,
  input  logic        cpu_rd_en,
  input  logic        cpu_wr_en,
  output logic [31:0] cpu_rdata,
  output logic        cpu_stall,
  output logic        mem_req,
  output logic        mem_we,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  input  logic [31:0] mem_rdata,
  input  logic        mem_ready,
  output logic [31:0] hit_count,
  output logic [31:0] miss_count
);

  localparam int IW = $clog2(SETS);
  localparam int TW = 30 - IW;

  typedef enum logic [1:0] {
    S_IDLE      = 2'd0,
    S_WRITEBACK = 2'd1,
    S_ALLOCATE  = 2'd2
  } state_t;

  state_t            state_q, state_d;
  logic [SETS-1:0]   valid_q, valid_d;
  logic [SETS-1:0]   dirty_q, dirty_d;
  logic [TW-1:0]     tag_q  [SETS];
  logic [31:0]       data_q [SETS];
  logic [IW-1:0]     miss_idx_q, miss_idx_d;
  logic [TW-1:0]     miss_tag_q, miss_tag_d;
  logic [TW-1:0]     victim_tag_q, victim_tag_d;
  logic [31:0]       victim_data_q, victim_data_d;
  logic [31:0]       hit_count_q, hit_count_d;
  logic [31:0]       miss_count_q, miss_count_d;

  logic [1:0]        off;
  logic [IW-1:0]     idx;
  logic [TW-1:0]     tag;
  logic [31:0]       line_word;
  logic              hit;
  logic              req;
  logic              line_we;
  logic [IW-1:0]     line_idx;
  logic [TW-1:0]     line_wtag;
  logic [31:0]       line_wdata;

  function automatic logic [31:0] load_fmt(input logic [31:0] w, input logic [2:0] m,
                                           input logic [1:0] o);
    logic [7:0]  b;
    logic [15:0] h;
    logic [31:0] r;
    b = w[{o, 3'b000} +: 8];
    h = o[1] ? w[31:16] : w[15:0];
    case (m)
      3'b000:  r = {{24{b[7]}}, b};
      3'b001:  r = {{16{h[15]}}, h};
      3'b100:  r = {24'd0, b};
      3'b101:  r = {16'd0, h};
      default: r = w;
    endcase
    return r;
  endfunction

  function automatic logic [31:0] store_merge(input logic [31:0] w, input logic [31:0] d,
                                              input logic [2:0] m, input logic [1:0] o);
    logic [3:0]  be;
    logic [31:0] src;
    logic [31:0] r;
    case (m)
      3'b000:  begin be = 4'b0001 << o;                src = {4{d[7:0]}};  end
      3'b001:  begin be = o[1] ? 4'b1100 : 4'b0011;    src = {2{d[15:0]}}; end
      default: begin be = 4'b1111;                     src = d;            end
    endcase
    for (int i = 0; i < 4; i++) begin
      r[8*i +: 8] = be[i] ? src[8*i +: 8] : w[8*i +: 8];
    end
    return r;
  endfunction

  assign off       = cpu_addr[1:0];
  assign idx       = cpu_addr[IW+1:2];
  assign tag       = cpu_addr[31:IW+2];
  assign line_word = data_q[idx];
  assign hit       = valid_q[idx] && (tag_q[idx] == tag);
  // Gating with reset keeps stall/rdata quiet while reset is held.
  assign req       = (cpu_rd_en | cpu_wr_en) & reset;

  always_comb begin
    state_d       = state_q;
    valid_d       = valid_q;
    dirty_d       = dirty_q;
    miss_idx_d    = miss_idx_q;
    miss_tag_d    = miss_tag_q;
    victim_tag_d  = victim_tag_q;
    victim_data_d = victim_data_q;
    hit_count_d   = hit_count_q;
    miss_count_d  = miss_count_q;
    line_we       = 1'b0;
    line_idx      = idx;
    line_wtag     = tag;
    line_wdata    = store_merge(line_word, cpu_wdata, cpu_mask, off);
    cpu_stall     = 1'b0;
    cpu_rdata     = 32'd0;
    mem_req       = 1'b0;
    mem_we        = 1'b0;
    mem_addr      = 32'd0;
    mem_wdata     = 32'd0;

    case (state_q)
      S_IDLE: begin
        if (req) begin
          if (hit) begin
            cpu_rdata = load_fmt(line_word, cpu_mask, off);
            if (cpu_wr_en) begin
              line_we      = 1'b1;
              dirty_d[idx] = 1'b1;
            end
            if (hit_count_q != 32'hFFFF_FFFF) hit_count_d = hit_count_q + 32'd1;
          end else begin
            cpu_stall     = 1'b1;
            miss_idx_d    = idx;
            miss_tag_d    = tag;
            victim_tag_d  = tag_q[idx];
            victim_data_d = line_word;
            if (miss_count_q != 32'hFFFF_FFFF) miss_count_d = miss_count_q + 32'd1;
            state_d = (valid_q[idx] && dirty_q[idx]) ? S_WRITEBACK : S_ALLOCATE;
          end
        end
      end
      S_WRITEBACK: begin
        cpu_stall = 1'b1;
        mem_req   = 1'b1;
        mem_we    = 1'b1;
        mem_addr  = {victim_tag_q, miss_idx_q, 2'b00};
        mem_wdata = victim_data_q;
        if (mem_ready) state_d = S_ALLOCATE;
      end
      S_ALLOCATE: begin
        cpu_stall = 1'b1;
        mem_req   = 1'b1;
        mem_addr  = {miss_tag_q, miss_idx_q, 2'b00};
        if (mem_ready) begin
          line_we             = 1'b1;
          line_idx            = miss_idx_q;
          line_wtag           = miss_tag_q;
          line_wdata          = mem_rdata;
          valid_d[miss_idx_q] = 1'b1;
          dirty_d[miss_idx_q] = 1'b0;
          state_d             = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q       <= S_IDLE;
      valid_q       <= '0;
      dirty_q       <= '0;
      miss_idx_q    <= '0;
      miss_tag_q    <= '0;
      victim_tag_q  <= '0;
      victim_data_q <= '0;
      hit_count_q   <= '0;
      miss_count_q  <= '0;
    end else begin
      state_q       <= state_d;
      valid_q       <= valid_d;
      dirty_q       <= dirty_d;
      miss_idx_q    <= miss_idx_d;
      miss_tag_q    <= miss_tag_d;
      victim_tag_q  <= victim_tag_d;
      victim_data_q <= victim_data_d;
      hit_count_q   <= hit_count_d;
      miss_count_q  <= miss_count_d;
    end
  end

  // Tag/data arrays carry no reset; valid bits qualify them.
  always_ff @(posedge clk) begin
    if (line_we) begin
      tag_q[line_idx]  <= line_wtag;
      data_q[line_idx] <= line_wdata;
    end
  end

  assign hit_count  = hit_count_q;
  assign miss_count = miss_count_q;

endmodule
`default_nettype wire

// File: tb/tb_l1_data_cache.sv
`default_nettype none
// Directed, table-driven bench for l1_data_cache with a latency-programmable memory model.
module tb_l1_data_cache;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic [31:0] cpu_addr = '0;
  logic [31:0] cpu_wdata = '0;
  logic [2:0]  cpu_mask = '0;
  logic        cpu_rd_en = 1'b0;
  logic        cpu_wr_en = 1'b0;
  logic [31:0] cpu_rdata;
  logic        cpu_stall;
  logic        mem_req;
  logic        mem_we;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic [31:0] mem_rdata = '0;
  logic        mem_ready = 1'b0;
  logic [31:0] hit_count;
  logic [31:0] miss_count;

  l1_data_cache #(.SETS(64)) dut (
    .clk(clk), .reset(reset),
    .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata), .cpu_mask(cpu_mask),
    .cpu_rd_en(cpu_rd_en), .cpu_wr_en(cpu_wr_en),
    .cpu_rdata(cpu_rdata), .cpu_stall(cpu_stall),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata), .mem_ready(mem_ready),
    .hit_count(hit_count), .miss_count(miss_count)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_err = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Memory model: responds after lat cycles of mem_req, commits write-backs next cycle.
  logic [31:0] mem [1024];
  int          lat = 1;
  int          cnt = 0;
  logic        p_we = 1'b0;
  logic [9:0]  p_widx = '0;
  logic [31:0] p_wdata = '0;

  always @(negedge clk) begin
    if (mem_ready) begin
      if (p_we) mem[p_widx] = p_wdata;
      mem_ready = 1'b0;
      cnt = 0;
    end
    if (mem_req) begin
      cnt++;
      if (cnt >= lat) begin
        mem_ready = 1'b1;
        mem_rdata = mem[mem_addr[11:2]];
        p_we      = mem_we;
        p_widx    = mem_addr[11:2];
        p_wdata   = mem_wdata;
      end
    end else begin
      cnt = 0;
    end
  end

  // Bus monitor: counts phase cycles and flags any mid-transaction change.
  int          tot_wb = 0, tot_al = 0, tot_unstable = 0;
  logic        prev_wb = 1'b0, prev_al = 1'b0;
  logic [31:0] wb_addr = '0, wb_data = '0, al_addr = '0;

  always @(negedge clk) begin
    if (mem_req && mem_we) begin
      if (!prev_wb) begin
        wb_addr = mem_addr;
        wb_data = mem_wdata;
      end else if (mem_addr !== wb_addr || mem_wdata !== wb_data) begin
        tot_unstable++;
      end
      tot_wb++;
    end
    if (mem_req && !mem_we) begin
      if (!prev_al) al_addr = mem_addr;
      else if (mem_addr !== al_addr) tot_unstable++;
      tot_al++;
    end
    prev_wb = mem_req && mem_we;
    prev_al = mem_req && !mem_we;
  end

  typedef struct {
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [2:0]  mask;
    logic        rd;
    logic        wr;
    int          lat;
    logic        chk_rd;
    logic [31:0] exp_rdata;
    int          exp_stall;
    int          exp_nwb;
    int          exp_nal;
    logic [31:0] exp_wb_addr;
    logic [31:0] exp_wb_data;
    logic [31:0] exp_al_addr;
  } vec_t;

  function automatic vec_t mk(input logic [31:0] a, input logic [31:0] wd, input logic [2:0] m,
                              input logic rd, input logic wr, input int l, input logic cr,
                              input logic [31:0] er, input int es, input int nw, input int na,
                              input logic [31:0] wa, input logic [31:0] wdd, input logic [31:0] aa);
    vec_t v;
    v.addr = a; v.wdata = wd; v.mask = m; v.rd = rd; v.wr = wr; v.lat = l;
    v.chk_rd = cr; v.exp_rdata = er; v.exp_stall = es; v.exp_nwb = nw; v.exp_nal = na;
    v.exp_wb_addr = wa; v.exp_wb_data = wdd; v.exp_al_addr = aa;
    return v;
  endfunction

  task automatic run_vec(input vec_t v, input int id);
    int stalls;
    int wb0, al0, un0;
    @(posedge clk); #1;
    cpu_addr = v.addr; cpu_wdata = v.wdata; cpu_mask = v.mask;
    cpu_rd_en = v.rd; cpu_wr_en = v.wr; lat = v.lat;
    wb0 = tot_wb; al0 = tot_al; un0 = tot_unstable;
    stalls = 0;
    @(negedge clk);
    while (cpu_stall && stalls < 100) begin
      stalls++;
      @(negedge clk);
    end
    if (v.chk_rd) chk($sformatf("v%0d rdata", id), cpu_rdata, v.exp_rdata);
    chk($sformatf("v%0d stall_cycles", id), 32'(stalls), 32'(v.exp_stall));
    chk($sformatf("v%0d wb_cycles", id), 32'(tot_wb - wb0), 32'(v.exp_nwb));
    chk($sformatf("v%0d alloc_cycles", id), 32'(tot_al - al0), 32'(v.exp_nal));
    if (v.exp_nwb > 0) begin
      chk($sformatf("v%0d wb_addr", id), wb_addr, v.exp_wb_addr);
      chk($sformatf("v%0d wb_data", id), wb_data, v.exp_wb_data);
    end
    if (v.exp_nal > 0) chk($sformatf("v%0d al_addr", id), al_addr, v.exp_al_addr);
    if (v.exp_stall > 0) chk($sformatf("v%0d bus_stable", id), 32'(tot_unstable - un0), 32'd0);
  endtask

  vec_t vt [19];

  initial begin
    int exp_hits;
    int exp_miss;
    for (int i = 0; i < 1024; i++) mem[i] = 32'h5A5A_0000 | i;
    mem[10'h040] = 32'hDEAD_BEEF;
    mem[10'h080] = 32'hCAFE_F00D;
    mem[10'h0FF] = 32'h1357_9BDF;
    mem[10'h140] = 32'h0BAD_F00D;

    //          addr          wdata         mask    rd    wr  lat chk  exp_rdata   stl wb al  wb_addr       wb_data       al_addr
    vt[0]  = mk(32'h0000_0100, 32'h0,        3'b010, 1'b1, 1'b0, 4, 1'b1, 32'hDEAD_BEEF, 5, 0, 4, 32'h0,        32'h0,        32'h0000_0100);
    vt[1]  = mk(32'h0000_0101, 32'h80,       3'b000, 1'b0, 1'b1, 1, 1'b0, 32'h0,         0, 0, 0, 32'h0,        32'h0,        32'h0);
    vt[2]  = mk(32'h0000_0101, 32'h0,        3'b000, 1'b1, 1'b0, 1, 1'b1, 32'hFFFF_FF80, 0, 0, 0, 32'h0,        32'h0,        32'h0);
    vt[3]  = mk(32'h0000_0101, 32'h0,        3'b100, 1'b1, 1'b0, 1, 1'b1, 32'h0000_0080, 0, 0, 0, 32'h0,        32'h0,        32'h0);
    vt[4]  = mk(32'h0000_0200, 32'h0,        3'b010, 1'b1, 1'b0, 2, 1'b1, 32'hCAFE_F00D, 5, 2, 2, 32'h0000_0100, 32'hDEAD_80EF, 32'h0000_0200);
    vt[5]  = mk(32'h0000_0102, 32'h1234,     3'b001, 1'b0, 1'b1, 3, 1'b0, 32'h0,         4, 0, 3, 32'h0,        32'h0,        32'h0000_0100);
    vt[6]  = mk(32'h0000_0102, 32'h0,        3'b001, 1'b1, 1'b0, 1, 1'b1, 32'h0000_1234, 0, 0, 0, 32'h0,        32'h0,        32'h0);
    vt[7]  = mk(32'h0000_0100, 32'h0,        3'b010, 1'b1, 1'b0, 1, 1'b1, 32'h1234_80EF, 0, 0, 0, 32'h0,        32'h0,        32'h0);
    vt[8]  = mk(32'h0000_0100, 32'h0,        3'b001, 1'b1, 1'b0, 1, 1'b1, 32'hFFFF_80EF, 0, 0, 0, 32'h0,        32'h0,        32'h0);
    vt[9]  = mk(32'h0000_0101, 32'h0,        3'b101, 1'b1, 1'b0, 1, 1'b1, 32'h0000_80EF, 0, 0, 0, 32'h0,        32'h0,        32'h0);
    vt[10] = mk(32'h0000_0103, 32'h0,        3'b000, 1'b1, 1'b0, 1, 1'b1, 32'h0000_0012, 0, 0, 0, 32'h0,        32'h0,        32'h0);
    vt[11] = mk(32'h0000_0100, 32'hA5A5_A5A5, 3'b010, 1'b1, 1'b1, 1, 1'b1, 32'h1234_80EF, 0, 0, 0, 32'h0,       32'h0,        32'h0);
    vt[12] = mk(32'h0000_0200, 32'h0,        3'b010, 1'b1, 1'b0, 1, 1'b1, 32'hCAFE_F00D, 3, 1, 1, 32'h0000_0100, 32'hA5A5_A5A5, 32'h0000_0200);
    vt[13] = mk(32'h0000_0202, 32'h0,        3'b011, 1'b1, 1'b0, 1, 1'b1, 32'hCAFE_F00D, 0, 0, 0, 32'h0,        32'h0,        32'h0);
    vt[14] = mk(32'h0000_03FC, 32'h0,        3'b010, 1'b1, 1'b0, 1, 1'b1, 32'h1357_9BDF, 2, 0, 1, 32'h0,        32'h0,        32'h0000_03FC);
    vt[15] = mk(32'h0000_0100, 32'h0,        3'b010, 1'b1, 1'b0, 1, 1'b1, 32'hA5A5_A5A5, 2, 0, 1, 32'h0,        32'h0,        32'h0000_0100);
    vt[16] = mk(32'h0000_03FF, 32'hFFFF_FF7E, 3'b000, 1'b0, 1'b1, 1, 1'b0, 32'h0,        0, 0, 0, 32'h0,        32'h0,        32'h0);
    vt[17] = mk(32'h0000_03FF, 32'h0,        3'b100, 1'b1, 1'b0, 1, 1'b1, 32'h0000_007E, 0, 0, 0, 32'h0,        32'h0,        32'h0);
    vt[18] = mk(32'h0000_03FE, 32'h0,        3'b000, 1'b1, 1'b0, 1, 1'b1, 32'h0000_0057, 0, 0, 0, 32'h0,        32'h0,        32'h0);

    // Reset state while reset is held low.
    repeat (2) @(negedge clk);
    chk("rst mem_req", {31'd0, mem_req}, 32'd0);
    chk("rst mem_we", {31'd0, mem_we}, 32'd0);
    chk("rst mem_addr", mem_addr, 32'd0);
    chk("rst mem_wdata", mem_wdata, 32'd0);
    chk("rst cpu_stall", {31'd0, cpu_stall}, 32'd0);
    chk("rst cpu_rdata", cpu_rdata, 32'd0);
    chk("rst hit_count", hit_count, 32'd0);
    chk("rst miss_count", miss_count, 32'd0);
    @(posedge clk); #1;
    reset = 1'b1;
    @(negedge clk);
    chk("idle rdata_no_req", cpu_rdata, 32'd0);

    exp_hits = 0;
    exp_miss = 0;
    for (int i = 0; i < 19; i++) begin
      run_vec(vt[i], i);
      exp_hits++;
      if (vt[i].exp_stall > 0) exp_miss++;
    end
    @(posedge clk); #1;
    cpu_rd_en = 1'b0; cpu_wr_en = 1'b0;
    chk("table hit_count", hit_count, 32'(exp_hits));
    chk("table miss_count", miss_count, 32'(exp_miss));
    @(negedge clk);
    chk("idle stall_no_req", {31'd0, cpu_stall}, 32'd0);

    // Reset during ALLOCATE: bus drops at once, counters clear, request misses again.
    @(posedge clk); #1;
    cpu_addr = 32'h0000_0500; cpu_mask = 3'b010; cpu_rd_en = 1'b1; lat = 10;
    repeat (3) @(negedge clk);
    chk("midrst alloc_req", {30'd0, mem_req, mem_we}, 32'd2);
    chk("midrst alloc_addr", mem_addr, 32'h0000_0500);
    #1 reset = 1'b0;
    #1;
    chk("midrst mem_req", {31'd0, mem_req}, 32'd0);
    chk("midrst cpu_stall", {31'd0, cpu_stall}, 32'd0);
    chk("midrst hit_count", hit_count, 32'd0);
    chk("midrst miss_count", miss_count, 32'd0);
    cpu_rd_en = 1'b0;
    @(negedge clk); #1;
    reset = 1'b1;
    run_vec(mk(32'h0000_0500, 32'h0, 3'b010, 1'b1, 1'b0, 2, 1'b1, 32'h0BAD_F00D, 3, 0, 2,
               32'h0, 32'h0, 32'h0000_0500), 100);
    @(posedge clk); #1;
    cpu_rd_en = 1'b0;
    chk("post_rst hit_count", hit_count, 32'd1);
    chk("post_rst miss_count", miss_count, 32'd1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

endmodule
`default_nettype wire
